// File: rtl/alu_pkg.sv
// Shared types for the RV32I execute stage.
// Op encoding, occupancy states and width defaults.
package alu_pkg;

  localparam int DEF_XLEN   = 32;
  localparam int DEF_REG_AW = 5;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_SLL  = 4'd2,
    OP_SLT  = 4'd3,
    OP_SLTU = 4'd4,
    OP_XOR  = 4'd5,
    OP_SRL  = 4'd6,
    OP_SRA  = 4'd7,
    OP_OR   = 4'd8,
    OP_AND  = 4'd9
  } alu_op_e;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

endpackage

// File: rtl/alu_core.sv
// Combinational RV32I integer ALU.
// Unassigned op codes yield 0 and flag illegal.
module alu_core
  import alu_pkg::*;
#(
  parameter int XLEN = DEF_XLEN
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [3:0]      op,
  output logic [XLEN-1:0] result,
  output logic            illegal
);

  logic [4:0] shamt;
  logic       lt_s;
  logic       lt_u;

  assign shamt = b[4:0];
  assign lt_u  = (a < b);
  assign lt_s  = (a[XLEN-1] != b[XLEN-1]) ?
                 a[XLEN-1] : lt_u;

  // Select the result for the decoded op
  always_comb begin
    result  = '0;
    illegal = 1'b0;
    case (alu_op_e'(op))
      OP_ADD:  result = a + b;
      OP_SUB:  result = a - b;
      OP_SLL:  result = a << shamt;
      OP_SLT:  result = {{(XLEN-1){1'b0}}, lt_s};
      OP_SLTU: result = {{(XLEN-1){1'b0}}, lt_u};
      OP_XOR:  result = a ^ b;
      OP_SRL:  result = a >> shamt;
      OP_SRA:  result = $unsigned($signed(a) >>> shamt);
      OP_OR:   result = a | b;
      OP_AND:  result = a & b;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_ex_stage.sv
// Execute stage: ALU followed by a 2-entry skid buffer.
// Optional ALU_EX_STAGE_STALL_CNT_EN adds a stall cycle counter.
module alu_ex_stage
  import alu_pkg::*;
#(
  parameter int XLEN   = DEF_XLEN,
  parameter int REG_AW = DEF_REG_AW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_op,
  input  logic [XLEN-1:0]   in_rs1,
  input  logic [XLEN-1:0]   in_rs2,
  input  logic [XLEN-1:0]   in_imm,
  input  logic              in_use_imm,
  input  logic [REG_AW-1:0] in_rd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_result,
  output logic [REG_AW-1:0] out_rd,
  output logic              out_illegal
`ifdef ALU_EX_STAGE_STALL_CNT_EN
  ,
  output logic [31:0]       stall_cnt
`endif
);

  occ_e              state;
  logic              acc;
  logic              drn;
  logic [XLEN-1:0]   opb;
  logic [XLEN-1:0]   res;
  logic              ill;
  logic [XLEN-1:0]   skid_result;
  logic [REG_AW-1:0] skid_rd;
  logic              skid_illegal;

  assign acc       = in_valid & in_ready;
  assign drn       = out_valid & out_ready;
  assign out_valid = (state != OCC_EMPTY);
  assign opb       = in_use_imm ? in_imm : in_rs2;

  alu_core #(
    .XLEN(XLEN)
  ) u_core (
    .a      (in_rs1),
    .b      (opb),
    .op     (in_op),
    .result (res),
    .illegal(ill)
  );

  // Occupancy FSM; head drives out_*, skid absorbs one stall
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= OCC_EMPTY;
      in_ready     <= 1'b1;
      out_result   <= '0;
      out_rd       <= '0;
      out_illegal  <= 1'b0;
      skid_result  <= '0;
      skid_rd      <= '0;
      skid_illegal <= 1'b0;
    end else begin
      case (state)
        OCC_EMPTY: begin
          if (acc) begin
            out_result  <= res;
            out_rd      <= in_rd;
            out_illegal <= ill;
            state       <= OCC_ONE;
          end
        end
        OCC_ONE: begin
          if (acc && drn) begin
            out_result  <= res;
            out_rd      <= in_rd;
            out_illegal <= ill;
          end else if (acc) begin
            skid_result  <= res;
            skid_rd      <= in_rd;
            skid_illegal <= ill;
            state        <= OCC_FULL;
            in_ready     <= 1'b0;
          end else if (drn) begin
            state <= OCC_EMPTY;
          end
        end
        OCC_FULL: begin
          if (drn) begin
            out_result  <= skid_result;
            out_rd      <= skid_rd;
            out_illegal <= skid_illegal;
            state       <= OCC_ONE;
            in_ready    <= 1'b1;
          end
        end
        default: begin
          state    <= OCC_EMPTY;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

`ifdef ALU_EX_STAGE_STALL_CNT_EN
  // Saturating count of cycles where writeback holds off a result
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready &&
                 stall_cnt != 32'hFFFF_FFFF) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_ex_stage.sv
// Scoreboard bench for alu_ex_stage.
// Random and directed ops against a reference model.
module tb_alu_ex_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_op;
  logic [31:0] in_rs1;
  logic [31:0] in_rs2;
  logic [31:0] in_imm;
  logic        in_use_imm;
  logic [4:0]  in_rd;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_rd;
  logic        out_illegal;
`ifdef ALU_EX_STAGE_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  always #5 clk = ~clk;

  alu_ex_stage dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_rs1     (in_rs1),
    .in_rs2     (in_rs2),
    .in_imm     (in_imm),
    .in_use_imm (in_use_imm),
    .in_rd      (in_rd),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_rd     (out_rd),
    .out_illegal(out_illegal)
`ifdef ALU_EX_STAGE_STALL_CNT_EN
    ,
    .stall_cnt  (stall_cnt)
`endif
  );

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    logic        ill;
  } exp_t;

  exp_t q[$];
  int   vectors = 0;
  int   miscompares = 0;
  bit   rand_rdy = 1'b0;

  task automatic check(string name, logic [31:0] act,
                       logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic exp_t model(logic [3:0] op,
                                 logic [31:0] a,
                                 logic [31:0] b,
                                 logic [4:0] rd);
    exp_t e;
    int unsigned sh;
    sh    = b % 32;
    e.rd  = rd;
    e.ill = 1'b0;
    case (op)
      4'd0: e.res = a + b;
      4'd1: e.res = a - b;
      4'd2: e.res = a << sh;
      4'd3: e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd4: e.res = (a < b) ? 32'd1 : 32'd0;
      4'd5: e.res = a ^ b;
      4'd6: e.res = a >> sh;
      4'd7: e.res = $signed(a) >>> sh;
      4'd8: e.res = a | b;
      4'd9: e.res = a & b;
      default: begin
        e.res = 32'd0;
        e.ill = 1'b1;
      end
    endcase
    return e;
  endfunction

  task automatic issue(logic [3:0] op, logic [31:0] a,
                       logic [31:0] r2, logic [31:0] imm,
                       logic use_imm, logic [4:0] rd);
    int n;
    in_op      = op;
    in_rs1     = a;
    in_rs2     = r2;
    in_imm     = imm;
    in_use_imm = use_imm;
    in_rd      = rd;
    in_valid   = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("accept_timeout", 0, 1);
    else q.push_back(model(op, a, use_imm ? imm : r2, rd));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic cyc(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: pop and compare every drained result
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid && out_ready) begin
      if (q.size() == 0) begin
        check("unexpected_out", 1, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("result", out_result, e.res);
        check("rd", {27'd0, out_rd}, {27'd0, e.rd});
        check("illegal", {31'd0, out_illegal}, {31'd0, e.ill});
      end
    end
  end

  // Random backpressure when enabled
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    longint t0;
    int     n;
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_op      = '0;
    in_rs1     = '0;
    in_rs2     = '0;
    in_imm     = '0;
    in_use_imm = 1'b0;
    in_rd      = '0;
    out_ready  = 1'b0;
    cyc(3);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", {31'd0, in_ready}, 1);
    check("rst_out_valid", {31'd0, out_valid}, 0);
    check("rst_out_result", out_result, 0);
    check("rst_out_rd", {27'd0, out_rd}, 0);
    check("rst_out_illegal", {31'd0, out_illegal}, 0);
    @(posedge clk);
    #1;

    out_ready = 1'b1;
    issue(4'd3, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b0, 5'd1);
    check("latency_valid", {31'd0, out_valid}, 1);
    check("slt_direct", out_result, 32'h1);
    issue(4'd4, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b0, 5'd2);
    check("sltu_direct", out_result, 32'h0);
    issue(4'd7, 32'h8000_0000, 32'h0, 32'h24, 1'b1, 5'd3);
    check("sra_direct", out_result, 32'hF800_0000);
    cyc(2);

    out_ready = 1'b0;
    issue(4'd0, 32'd2, 32'd3, 32'd0, 1'b0, 5'd4);
    issue(4'd1, 32'd2, 32'd3, 32'd0, 1'b0, 5'd5);
    check("full_in_ready", {31'd0, in_ready}, 0);
    check("full_head", out_result, 32'd5);
    out_ready = 1'b1;
    cyc(1);
    check("skid_head", out_result, 32'hFFFF_FFFF);
    cyc(2);
    check("drained", q.size(), 0);

    t0 = $time;
    for (int i = 0; i < 10; i++) begin
      issue(4'($urandom_range(0, 9)), $urandom, $urandom,
            $urandom, 1'($urandom_range(0, 1)), 5'($urandom));
      check("b2b_valid", {31'd0, out_valid}, 1);
      check("b2b_ready", {31'd0, in_ready}, 1);
    end
    check("b2b_cycles", 32'(($time - t0) / 10), 10);
    cyc(2);

    issue(4'hF, 32'h1234_5678, 32'h1, 32'h0, 1'b0, 5'd9);
    check("illegal_flag", {31'd0, out_illegal}, 1);
    check("illegal_res", out_result, 0);
    cyc(2);

    out_ready = 1'b0;
    issue(4'd0, 32'd7, 32'd8, 32'd0, 1'b0, 5'd10);
    issue(4'd0, 32'd9, 32'd8, 32'd0, 1'b0, 5'd11);
    rst_n = 1'b0;
    q.delete();
    cyc(1);
    check("midrst_valid", {31'd0, out_valid}, 0);
    check("midrst_ready", {31'd0, in_ready}, 1);
    rst_n = 1'b1;
    cyc(1);

    rand_rdy = 1'b1;
    for (int i = 0; i < 300; i++) begin
      logic [31:0] a;
      logic [31:0] b;
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
      if ($urandom_range(0, 7) == 0) b = 32'hFFFF_FFFF;
      issue(4'($urandom_range(0, 15)), a, b, $urandom,
            1'($urandom_range(0, 1)), 5'($urandom));
      if ($urandom_range(0, 3) == 0) cyc(1);
    end
    rand_rdy  = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while (q.size() != 0 && n < 50) begin
      cyc(1);
      n++;
    end
    check("final_drain", q.size(), 0);

`ifdef ALU_EX_STAGE_STALL_CNT_EN
    rst_n = 1'b0;
    out_ready = 1'b0;
    q.delete();
    cyc(1);
    rst_n = 1'b1;
    check("stall_rst", stall_cnt, 0);
    issue(4'd0, 32'd1, 32'd1, 32'd0, 1'b0, 5'd1);
    cyc(7);
    check("stall_seven", stall_cnt, 7);
    force dut.stall_cnt = 32'hFFFF_FFFD;
    #1;
    release dut.stall_cnt;
    cyc(5);
    check("stall_sat", stall_cnt, 32'hFFFF_FFFF);
    out_ready = 1'b1;
    cyc(2);
    check("stall_drain", q.size(), 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_ex_stage.md
Name: alu_ex_stage

Overview:
- Execute-stage wrapper for the RV32I integer ALU.
- Accepts decoded operands from the issue stage over a valid/ready handshake and selects operand B (register or immediate).
- Computes the result for the selected op (ADD/SUB/SLT/SLTU/logic/shift) and holds it in a 2-entry skid buffer toward writeback.
- Decouples issue from writeback stalls without a combinational ready path.

Parameters:
- XLEN, 32, datapath width.
- REG_AW, 5, destination register index width.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous reset, active low
- in_valid  in  1  issue has an operation
- in_ready  out  1  stage can accept an operation this cycle
- in_op  in  4  ALU op code (alu_pkg encoding)
- in_rs1  in  XLEN  operand A
- in_rs2  in  XLEN  register operand B
- in_imm  in  XLEN  sign-extended immediate
- in_use_imm  in  1  1: operand B = in_imm; 0: operand B = in_rs2
- in_rd  in  REG_AW  destination register
- out_valid  out  1  result available
- out_ready  in  1  writeback consumes result
- out_result  out  XLEN  ALU result
- out_rd  out  REG_AW  destination register of out_result
- out_illegal  out  1  op code was unassigned (result forced to 0)

Behaviour:
- One clock, clk rising edge.
- Reset is synchronous, active low on rst_n.
- Reset values: occupancy = EMPTY, out_valid=0, in_ready=1, out_result=0, out_rd=0, out_illegal=0.
- Reset mid-operation discards both buffer entries.
- Accept fires when in_valid & in_ready. Issue must hold its inputs stable while in_valid=1 and in_ready=0.
- Drain fires when out_valid & out_ready.
- Latency: an op accepted in cycle N appears on out_* in cycle N+1 when the buffer was EMPTY.
- Ordering is strict FIFO.
- Occupancy state machine (states EMPTY, ONE, FULL):
  - EMPTY: accept -> ONE.
  - ONE: accept & !drain -> FULL; drain & !accept -> EMPTY; accept & drain -> ONE, new entry becomes head.
  - FULL: drain -> ONE, skid entry moves to head. Accept is impossible because in_ready=0.
- in_ready is a registered output: 1 in EMPTY and ONE, 0 in FULL. It never depends combinationally on out_ready.
- out_valid = (state != EMPTY). Head entry drives out_result, out_rd and out_illegal.
- Ops and results:
  - ADD, SUB: modulo 2^XLEN.
  - AND, OR, XOR: bitwise.
  - SLL, SRL, SRA: shift amount is operand B[4:0]; upper bits of B are ignored.
  - SLT: signed compare. If the sign bits differ, result = A[MSB]; otherwise result = unsigned compare of A and B.
  - SLTU: unsigned compare.
  - SLT and SLTU results are zero-extended: bit 0 only, bits XLEN-1:1 = 0.
  - Unassigned op codes: result 0, out_illegal=1 for that entry.
- The result is computed combinationally from the in_* signals and captured at accept.

Optional Feature:
- Macro: ALU_EX_STAGE_STALL_CNT_EN.
- Defined:
  - Adds output stall_cnt (32 bits).
  - Counts cycles with out_valid=1 & out_ready=0.
  - Saturates at 0xFFFFFFFF; does not wrap.
  - Cleared by reset.
- Undefined: port and counter absent; all other behaviour identical.

Decomposition:
- alu_pkg holds:
  - The op encoding as a 4-bit typedef: ADD=0, SUB=1, SLL=2, SLT=3, SLTU=4, XOR=5, SRL=6, SRA=7, OR=8, AND=9; 10-15 unassigned.
  - The occupancy state typedef.
  - XLEN default.
- One combinational sub-module, alu_core (A, B, op -> result, illegal), instantiated once before the skid buffer.

Test Plan:
- Reset release, EMPTY: in_ready=1, out_valid=0. Accept SLT, A=0xFFFFFFFF, B=0x00000001 -> next cycle out_result=0x00000001.
- SLTU with the same operands -> out_result=0. SRA, A=0x80000000, B=0x00000024 (shamt 4) -> 0xF8000000.
- out_ready=0, two back-to-back accepts (ADD 2+3, SUB 2-3) -> in_ready=0 after the second. Then out_ready=1 -> 0x00000005, then 0xFFFFFFFF, in order.
- Simultaneous accept and drain in ONE, over 10 consecutive cycles -> state stays ONE, one result per cycle, no bubble.
- Op code 0xF -> out_result=0, out_illegal=1. rst_n=0 while FULL -> next cycle out_valid=0, in_ready=1.
- With ALU_EX_STAGE_STALL_CNT_EN defined: 7 stall cycles -> stall_cnt=7. Counter preloaded near max -> holds at 0xFFFFFFFF.
